// File: rtl/alu_muldiv_ctrl_pkg.sv
// alu_muldiv_ctrl_pkg: ALU-control codes, funct constants and mul/div FSM states.
package alu_muldiv_ctrl_pkg;
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLLV = 4'b1100;
  localparam logic [3:0] ALU_SRLV = 4'b1101;
  localparam logic [3:0] ALU_SRAV = 4'b1110;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// alu_muldiv_ctrl_muldiv_iter: shift-add multiply / restoring divide datapath with sign fix.
module alu_muldiv_ctrl_muldiv_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              step,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);
  logic [2*DATA_W-1:0] acc, prod;
  logic [DATA_W-1:0]   rem, b_mag, a_mag_c, b_mag_c, quo, rmd;
  logic [DATA_W:0]     sum, shifted, diff;
  logic [CNT_W-1:0]    cnt;
  logic                div_mode, neg_q, neg_r, a_neg, b_neg;
  assign a_neg   = is_signed & a[DATA_W-1];
  assign b_neg   = is_signed & b[DATA_W-1];
  assign a_mag_c = a_neg ? -a : a;
  assign b_mag_c = b_neg ? -b : b;
  assign sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign shifted = {rem, acc[DATA_W-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign done    = cnt == CNT_W'(1);
  assign prod    = neg_q ? -acc : acc;
  assign quo     = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rmd     = neg_r ? -rem : rem;
  assign res_hi  = div_mode ? rmd : prod[2*DATA_W-1:DATA_W];
  assign res_lo  = div_mode ? quo : prod[DATA_W-1:0];
  // divide-by-zero preloads the raw result with sign fix disabled so FIX passes it through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rem      <= '0;
      b_mag    <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (start) begin
      div_mode <= is_div;
      cnt      <= CNT_W'(DATA_W);
      b_mag    <= b_mag_c;
      if (is_div && b == '0) begin
        acc   <= {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
        rem   <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        acc   <= {{DATA_W{1'b0}}, a_mag_c};
        rem   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
      if (div_mode) begin
        rem              <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        acc[DATA_W-1:0]  <= {acc[DATA_W-2:0], ~diff[DATA_W]};
      end else begin
        acc <= {sum, acc[DATA_W-1:1]};
      end
    end
  end
endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU-control decode plus multi-cycle mul/div engine with HI/LO and stall.
module alu_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] hilo_rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall
);
  import alu_muldiv_ctrl_pkg::*;
  state_t            state, state_nx;
  logic              hl_op, md_op, mt_op, mf_op, idle_go, start, div_zero, done;
  logic [DATA_W-1:0] res_hi, res_lo;
  // MF/MT/MULT/DIV all sit in funct 01x0xx; bit 3 separates engine ops from moves
  assign hl_op        = issue & (alu_op == 2'b10) & (funct[5:4] == 2'b01) & ~funct[2];
  assign md_op        = hl_op & funct[3];
  assign mt_op        = hl_op & ~funct[3] & funct[0];
  assign mf_op        = hl_op & ~funct[3] & ~funct[0];
  assign busy         = state != ST_IDLE;
  assign stall        = hl_op & busy;
  assign idle_go      = ~busy & ~flush;
  assign start        = md_op & idle_go;
  assign div_zero     = funct[1] & (rt_data == '0);
  assign hilo_rd_data = mf_op ? (funct[1] ? lo : hi) : '0;
  always_comb begin
    alu_ctrl = ALU_NONE;
    if (alu_op == 2'b00) alu_ctrl = ALU_ADD;
    else if (alu_op == 2'b01) alu_ctrl = ALU_SUB;
    else if (alu_op == 2'b10)
      case (funct)
        F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
        F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
        F_AND:         alu_ctrl = ALU_AND;
        F_OR:          alu_ctrl = ALU_OR;
        F_XOR:         alu_ctrl = ALU_XOR;
        F_NOR:         alu_ctrl = ALU_NOR;
        F_SLT:         alu_ctrl = ALU_SLT;
        F_SLTU:        alu_ctrl = ALU_SLTU;
        F_SLL:         alu_ctrl = ALU_SLL;
        F_SRL:         alu_ctrl = ALU_SRL;
        F_SRA:         alu_ctrl = ALU_SRA;
        F_SLLV:        alu_ctrl = ALU_SLLV;
        F_SRLV:        alu_ctrl = ALU_SRLV;
        F_SRAV:        alu_ctrl = ALU_SRAV;
        default:       alu_ctrl = ALU_NONE;
      endcase
  end
  always_comb begin
    state_nx = flush ? ST_IDLE
             : state == ST_IDLE ? (start ? (funct[1] ? (div_zero ? ST_FIX : ST_DIV) : ST_MUL) : ST_IDLE)
             : (state == ST_MUL || state == ST_DIV) ? (done ? ST_FIX : state)
             : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX && !flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_op && idle_go) begin
      if (funct[1]) lo <= rs_data;
      else hi <= rs_data;
    end
  end
  alu_muldiv_ctrl_muldiv_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_div    (funct[1]),
    .is_signed (~funct[0]),
    .a         (rs_data),
    .b         (rt_data),
    .step      (state == ST_MUL || state == ST_DIV),
    .done      (done),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed vectors; mul/div results checked by a scoreboard on busy fall.
module tb_alu_muldiv_ctrl;
  import alu_muldiv_ctrl_pkg::*;
  logic        clk = 0, rst_n = 0, issue = 0, flush = 0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic [3:0]  alu_ctrl;
  logic [31:0] hilo_rd_data, hi, lo;
  logic        busy, stall;
  int          total = 0, bad = 0, mon_run = 0;
  logic        mon_pb = 0;
  typedef struct {string tag; logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
  exp_t sb[$];

  alu_muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .flush(flush), .alu_op(alu_op),
    .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .alu_ctrl(alu_ctrl),
    .hilo_rd_data(hilo_rd_data), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic go(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue = 1; alu_op = 2'b10; funct = f; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    issue = 0; funct = 6'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk({tag, "_timeout"}, {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) mon_run++;
      else if (mon_pb) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got busy fall want none");
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_hi"}, hi, e.hi);
          chk({e.tag, "_lo"}, lo, e.lo);
          if (e.cyc != 0) chk({e.tag, "_cycles"}, mon_run, e.cyc);
        end
        mon_run = 0;
      end
      mon_pb = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    alu_op = 2'b10; funct = F_SLTU; #1 chk("dec_sltu", {28'b0, alu_ctrl}, 32'd8);
    funct = F_SUBU; #1 chk("dec_subu", {28'b0, alu_ctrl}, 32'd6);
    funct = F_NOR;  #1 chk("dec_nor", {28'b0, alu_ctrl}, 32'd5);
    funct = 6'b111111; #1 chk("dec_bad", {28'b0, alu_ctrl}, 32'd0);
    alu_op = 2'b00; #1 chk("dec_ldst", {28'b0, alu_ctrl}, 32'd2);
    alu_op = 2'b01; #1 chk("dec_br", {28'b0, alu_ctrl}, 32'd6);
    alu_op = 2'b11; #1 chk("dec_op11", {28'b0, alu_ctrl}, 32'd0);
    @(posedge clk); #1;

    push("mult", 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    go(F_MULT, 32'd7, 32'hFFFFFFFD); wait_idle("mult");
    push("multu", 32'h00000001, 32'hFFFFFFFE, 33);
    go(F_MULTU, 32'hFFFFFFFF, 32'd2); wait_idle("multu");
    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    go(F_DIV, 32'hFFFFFFF9, 32'd2); wait_idle("div");
    push("divz", 32'h0000000A, 32'hFFFFFFFF, 1);
    go(F_DIVU, 32'd10, 32'd0); wait_idle("divz");

    push("m35", 32'd0, 32'd15, 33);
    go(F_MULT, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1 issue = 1; alu_op = 2'b10; funct = F_MFLO;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) chk("mflo_stall", {31'b0, stall}, 1);
      else begin
        chk("mflo_release", {31'b0, stall}, 0);
        chk("mflo_data", hilo_rd_data, 32'd15);
        ok = 1;
        break;
      end
    end
    chk("mflo_timeout", {31'b0, ok}, 1);
    @(posedge clk); #1 issue = 0;

    issue = 1; funct = F_MTHI; rs_data = 32'h1234;
    #1 chk("mthi_stall", {31'b0, stall}, 0);
    @(posedge clk); #1 issue = 0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd15);

    push("rst", 32'd0, 32'd0, 0);
    go(F_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_stall", {31'b0, stall}, 0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    push("divu", 32'd2, 32'd14, 33);
    go(F_DIVU, 32'd100, 32'd7); wait_idle("divu");

    push("flush", 32'd2, 32'd14, 10);
    go(F_MULT, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1; issue = 1; alu_op = 2'b10; funct = F_MULT; rs_data = 3; rt_data = 3;
    @(posedge clk); #1 flush = 0; issue = 0;
    chk("flush_busy", {31'b0, busy}, 0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    @(posedge clk); #1;
    chk("flush_newop_ignored", {31'b0, busy}, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
- Next-generation execution-stage ALU control block.
- Keeps the combinational funct/ALU_op to 4-bit ALU-control decode.
- Adds a parametrised multi-cycle multiply/divide engine with HI/LO registers, MFHI/MFLO/MTHI/MTLO handling and a pipeline stall handshake.
- Sits in EX, beside the ALU. Stall feeds the hazard unit.

Parameters:
DATA_W, 32, operand/HI/LO width (even, >= 8)
CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue  in  1  valid instruction present in EX this cycle
flush  in  1  abort in-flight mul/div, discard result
alu_op  in  2  00 load/store, 01 branch, 10 R-type
funct  in  6  R-type funct field
rs_data  in  DATA_W  operand A / dividend / MT source
rt_data  in  DATA_W  operand B / divisor
alu_ctrl  out  4  ALU operation code (combinational)
hilo_rd_data  out  DATA_W  HI (MFHI) or LO (MFLO), else 0
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  engine not IDLE
stall  out  1  hold EX and upstream stages this cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, counter=0, busy=0, stall=0. Reset mid-operation aborts and leaves HI/LO=0.
- alu_ctrl decode:
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 10 -> funct table: ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV.
  - SLTU (101011) has its own code, distinct from SUBU (100011).
  - Unlisted funct, or alu_op 11 -> 4'b0000.
  - All codes come from the shared definitions header.
- Mul/div funct values: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. They act only when issue=1 and alu_op=10.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - On MULT/MULTU/DIV/DIVU with stall=0, latch at that edge: operand magnitudes (signed ops take absolute value), result-sign flags, counter=DATA_W. Go to MUL or DIV.
  - DIV/DIVU with rt_data=0: go directly to FIX with lo={DATA_W{1}}, hi=rs_data (raw).
- MUL: one shift-add step per cycle, 2*DATA_W accumulator, counter decrements. At counter==1 go to FIX.
- DIV: one restoring step per cycle (remainder DATA_W+1 bits), counter decrements. At counter==1 go to FIX.
- FIX:
  - Apply signs: product negated if sign flags differ; quotient negated likewise; remainder takes the dividend sign.
  - Write hi/lo at the edge leaving FIX. Go to IDLE.
  - Latency: hi/lo valid DATA_W+1 cycles after the issue edge; busy high for exactly those cycles.
- MTHI/MTLO: when idle, write rs_data at the next edge.
- MFHI/MFLO: hilo_rd_data = hi/lo combinationally.
- stall=1 when issue=1, alu_op=10, busy=1, and funct is any of the eight mul/div/MF/MT codes. The instruction then re-presents until busy drops.
  - Simultaneous FIX and MFLO: stall (busy still 1); the next cycle returns the new value.
  - A mul/div issued on the cycle busy falls is accepted.
- flush=1: state goes to IDLE at the next edge; hi/lo unchanged; flush has priority over a new issue in the same cycle.
- Non-mul/div instructions never stall and never touch the engine.

Decomposition:
- Shared definitions header holds the ALU-control codes, funct constants (including the eight mul/div codes) and FSM state encodings.
- One natural sub-module: muldiv_iter. It holds the datapath (accumulator, remainder, counter, sign fix) with start/mode/done ports. The parent holds decode, FSM, HI/LO and stall.

Test Plan:
- alu_op=10, funct=101011 -> alu_ctrl=SLTU; funct=100011 -> SUBU; alu_op=00 -> ADD; funct=111111 -> 0000.
- MULT 7 x 0xFFFFFFFD -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 10/0 -> lo=0xFFFFFFFF, hi=0x0000000A after one FIX cycle.
- MFLO issued 5 cycles after MULT -> stall high until busy falls; hilo_rd_data then equals the new lo; MTHI 0x1234 while idle -> hi=0x1234 next cycle, no stall.
- rst_n pulled low mid-DIV -> immediately hi=lo=0, busy=0, stall=0; a subsequent DIVU 100/7 gives lo=14, hi=2.
- flush on cycle 10 of MULT -> busy=0 next cycle, hi/lo keep their prior values; a new MULT issued together with flush is ignored.
